// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_e  : detector FSM encoding (UNCFG = no legal pattern held, RUN = detecting)
//   len_mask : builds a right-aligned mask of pat_len ones, used to ignore
//              pattern/history bits at or above the configured length.
package seq_detect_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Widest pattern the mask helper supports; MAX_LEN of any instance must not exceed it.
  localparam int unsigned MAX_LEN_LIMIT = 16;

  function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input int unsigned len);
    logic [MAX_LEN_LIMIT-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN_LIMIT; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register plus saturating fill counter for the pattern detector.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clear history and fill (new configuration)
//   shift       : accept bit_in as the newest history bit
//   bit_in      : serial bit to shift in
//   fill_zero   : force the stored fill to 0 at this edge (non-overlap restart);
//                 it does not affect the look-ahead values below
//   hist_q/fill_q     : registered history (bit 0 newest) and fill
//   hist_nxt/fill_nxt : values after this cycle's clear/shift, before fill_zero,
//                       so the top can evaluate the match on the updated history
module seq_hist_shreg #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  input  logic               fill_zero,
  output logic [MAX_LEN-1:0] hist_q,
  output logic [LEN_W-1:0]   fill_q,
  output logic [MAX_LEN-1:0] hist_nxt,
  output logic [LEN_W-1:0]   fill_nxt
);

  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;

  always_comb begin
    hist_nxt = hist_q;
    fill_nxt = fill_q;
    if (clr) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (shift) begin
      hist_nxt = {hist_q[MAX_LEN-2:0], bit_in};
      // Fill saturates at MAX_LEN: beyond that every history bit is valid.
      fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    end
  end

  always_comb begin
    hist_d = hist_nxt;
    fill_d = fill_zero ? '0 : fill_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   inp_bit      : serial data bit
//   inp_valid    : qualifier; inp_bit is consumed only in cycles where it is high
//                  (no backpressure: the detector always accepts a valid bit)
//   cfg_load     : one-cycle strobe latching pattern/pat_len/cfg_overlap
//   pattern      : pattern bits, pattern[pat_len-1] received first, pattern[0] last
//   pat_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping matches, 0 = each match needs pat_len fresh bits
//   seq_seen     : one-cycle pulse, the cycle after the completing bit is sampled
//   match_count  : saturating match count since reset / last legal config
//   armed        : a legal config is held and detection is running
//   cfg_err      : one-cycle pulse after a cfg_load with illegal pat_len
// state_q is the FSM observation point for checkers.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               cfg_overlap,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   pat_len_q, pat_len_d;
  logic               overlap_q, overlap_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               seq_seen_q, seq_seen_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_legal;
  logic               clr;
  logic               shift;
  logic               fill_zero;
  logic               match;

  logic [MAX_LEN-1:0] hist_q, hist_nxt;
  logic [LEN_W-1:0]   fill_q, fill_nxt;
  logic [MAX_LEN_LIMIT-1:0] mask_full;
  logic [MAX_LEN_LIMIT-1:0] diff_full;

  assign cfg_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  // cfg_load owns the cycle: any bit presented alongside it is dropped.
  assign clr   = cfg_load & cfg_legal;
  assign shift = ~cfg_load & (state_q == RUN) & inp_valid;

  // Compare on the post-shift history; bits at or above pat_len are masked off.
  assign mask_full = len_mask(32'(pat_len_q));
  assign diff_full = MAX_LEN_LIMIT'(hist_nxt ^ pattern_q) & mask_full;
  assign match     = shift && (fill_nxt >= pat_len_q) && (diff_full == '0);

  assign fill_zero = match & ~overlap_q;

  seq_hist_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .shift     (shift),
    .bit_in    (inp_bit),
    .fill_zero (fill_zero),
    .hist_q    (hist_q),
    .fill_q    (fill_q),
    .hist_nxt  (hist_nxt),
    .fill_nxt  (fill_nxt)
  );

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pat_len_d  = pat_len_q;
    overlap_d  = overlap_q;
    count_d    = count_q;
    seq_seen_d = 1'b0;
    cfg_err_d  = 1'b0;

    if (cfg_load) begin
      if (cfg_legal) begin
        state_d   = RUN;
        pattern_d = pattern;
        pat_len_d = pat_len;
        overlap_d = cfg_overlap;
        count_d   = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (match) begin
      seq_seen_d = 1'b1;
      count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNCFG;
      pattern_q  <= '0;
      pat_len_q  <= '0;
      overlap_q  <= 1'b0;
      count_q    <= '0;
      seq_seen_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pat_len_q  <= pat_len_d;
      overlap_q  <= overlap_d;
      count_q    <= count_d;
      seq_seen_q <= seq_seen_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign seq_seen    = seq_seen_q;
  assign match_count = count_q;
  assign armed       = (state_q == RUN);
  assign cfg_err     = cfg_err_q;

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Runtime-programmable serial bit-pattern detector that generalises the fixed 4-bit detector.
- Pattern of 1..MAX_LEN bits, loaded through a config strobe.
- Overlapping or non-overlapping match mode.
- Valid-qualified input stream.
- Saturating match counter.
- Sits on serial receive paths as a frame/sync-word detector feeding control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 5, width of pat_len; must hold MAX_LEN
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
inp_bit  input  1  serial data bit
inp_valid  input  1  inp_bit is sampled only when high
cfg_load  input  1  one-cycle strobe; latches pattern/pat_len/cfg_overlap
pattern  input  MAX_LEN  pattern bits; pattern[pat_len-1] is received first, pattern[0] last
pat_len  input  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
seq_seen  output  1  one-cycle pulse per match
match_count  output  CNT_W  saturating count of matches since reset/config
armed  output  1  high when a legal config is held and detection is active
cfg_err  output  1  one-cycle pulse when cfg_load carries an illegal pat_len

Behaviour:
- Reset (synchronous, active-high): FSM to UNCFG; history, fill count and match_count to 0; seq_seen, armed, cfg_err to 0; latched config to 0. Reset wins over all other inputs, including mid-stream.
- States:
  - UNCFG: inputs ignored.
  - RUN: detection active.
- cfg_load:
  - pat_len in 1..MAX_LEN: latch pattern, pat_len and cfg_overlap; clear history, fill count and match_count; go to RUN. armed=1 from the next cycle.
  - Illegal pat_len (0 or >MAX_LEN): cfg_err=1 next cycle; state, config and counters unchanged.
  - cfg_load has priority over inp_valid in the same cycle; that input bit is discarded.
- RUN, inp_valid=1:
  - history <= {history[MAX_LEN-2:0], inp_bit}; history[0] is the newest bit.
  - fill <= min(fill+1, MAX_LEN).
- inp_valid=0: no state change; gaps are transparent.
- Match condition, evaluated on the updated history and fill:
  - fill >= pat_len, and
  - history[pat_len-1:0] == pattern[pat_len-1:0]; bits at or above pat_len are masked.
- Latency: seq_seen is registered and goes high in the cycle after the edge that samples the completing bit. It is high for exactly one cycle per match; back-to-back matches give consecutive pulses.
- On match: match_count increments and saturates at 2^CNT_W-1. It updates in the same cycle seq_seen is high.
- Overlap mode (cfg_overlap=1): fill is not cleared on a match; suffix bits may start the next match.
- Non-overlap mode (cfg_overlap=0): fill is forced to 0 on a match, so the next match needs pat_len fresh bits.
- pat_len=1: every valid bit equal to pattern[0] matches, in both modes.
- Config is static during RUN. pattern/pat_len/cfg_overlap changes without cfg_load have no effect.

Decomposition:
- Package seq_detect_pkg holds:
  - FSM state constants UNCFG=0, RUN=1.
  - A function computing the length mask from pat_len.
- One natural sub-module: seq_hist_shreg. It holds the MAX_LEN history register plus the saturating fill counter, with shift-enable and clear inputs.
- The FSM, comparator and match counter stay in the top.

Test Plan:
- Config pattern=4'b1011, pat_len=4, overlap=1, then stream 1,0,1,1,0,1,1 on consecutive valid cycles -> seq_seen pulses after bit 4 and bit 7; match_count=2.
- Same stream with overlap=0 -> single pulse after bit 4; match_count=1.
- overlap=0, stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8; match_count=2.
- CNT_W=2, pat_len=1, pattern=1, eight consecutive valid 1s -> eight seq_seen pulses; match_count stops at 3.
- cfg_load with pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err pulses twice; armed stays 0; no seq_seen on any stream.
- 1011 with inp_valid low between every bit -> one pulse after the 4th valid bit. Assert reset after bit 3 of a second 1011 -> all outputs 0, armed=0, no pulse after bit 4.
